contador_prog: RTL and testbench

CONTADOR_PROG -- requirements
Module: contador_prog

---
 rtl/contador_prog.sv | 154 +++++++++++++++
 tb/tb_contador_prog.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_prog.sv
`default_nettype none
// ============================================================================
//  Module      : contador_prog
//  Description : Programmable up/down counter with a runtime-writable
//                terminal/reload limit, auto-reload or one-shot behaviour,
//                74x163-style dual count enables (ent/enp) and a
//                combinational ripple-carry style terminal indication.
//                Optional step prescaler compiled in when the macro
//                CONTADOR_PRESCALER_EN is defined (adds input presc[7:0]).
//  Revision    : 1.0 - initial release
// ============================================================================

module contador_prog #(
    parameter int N            = 16,
    parameter int LIMITE_RESET = 2000
) (
    input  logic         clock,
    input  logic         clr_n,
    input  logic         ld,
    input  logic [N-1:0] D,
    input  logic         ent,
    input  logic         enp,
    input  logic         up,
    input  logic         one_shot,
    input  logic         wr_lim,
    input  logic [N-1:0] lim_in,
`ifdef CONTADOR_PRESCALER_EN
    input  logic [7:0]   presc,
`endif
    output logic [N-1:0] Q,
    output logic         rco,
    output logic         done
);

    // Limit value restored on reset, truncated to the counter width.
    localparam logic [N-1:0] c_lim_reset = N'(LIMITE_RESET);
    localparam logic [N-1:0] c_one       = N'(1);

    // ------------------------------------------------------------------
    // State registers. Declaration values give the same power-up state
    // as a reset edge.
    // ------------------------------------------------------------------
    logic [N-1:0] q_q    = '0;
    logic [N-1:0] q_d;
    logic         done_q = 1'b0;
    logic         done_d;
    logic [N-1:0] lim_q  = c_lim_reset;
    logic [N-1:0] lim_d;

    // Combinational helpers.
    logic         w_terminal;   // count is at (or beyond) its end point
    logic         w_qual;       // both enables present and not finished
    logic         w_step;       // a count step happens at this edge

`ifdef CONTADOR_PRESCALER_EN
    logic [7:0]   pcnt_q = '0;
    logic [7:0]   pcnt_d;
    logic         w_tick;
`endif

    // Terminal detection: in up mode anything at or above the limit is
    // terminal, so a value loaded above a shrunken limit still wraps
    // instead of running towards 2^N.
    always_comb begin
        w_terminal = 1'b0;
        if (up) begin
            w_terminal = (q_q >= lim_q);
        end else begin
            w_terminal = (q_q == '0);
        end
    end

    assign rco    = ent & w_terminal;
    assign w_qual = ent & enp & ~done_q;

`ifdef CONTADOR_PRESCALER_EN
    // Step only once the prescaler has seen presc+1 qualified cycles; the
    // >= compare keeps it from stalling if presc is lowered mid-count.
    always_comb begin
        w_tick = (pcnt_q >= presc);
        w_step = w_qual & w_tick;
    end

    // Prescaler count: restart on load or step, advance on qualified cycles.
    always_comb begin
        pcnt_d = pcnt_q;
        if (ld || w_step) begin
            pcnt_d = '0;
        end else if (w_qual) begin
            pcnt_d = pcnt_q + 8'd1;
        end
    end
`else
    // Without prescaler every qualified enable cycle is a step.
    always_comb begin
        w_step = w_qual;
    end
`endif

    // Next-state for count, completion flag and limit: load beats step,
    // limit write is independent of counting.
    always_comb begin
        q_d    = q_q;
        done_d = done_q;
        lim_d  = lim_q;

        if (wr_lim) begin
            lim_d = lim_in;
        end

        if (ld) begin
            q_d    = D;
            done_d = 1'b0;
        end else if (w_step) begin
            if (!w_terminal) begin
                q_d = up ? (q_q + c_one) : (q_q - c_one);
            end else if (!one_shot) begin
                q_d = up ? '0 : lim_q;
            end else begin
                done_d = 1'b1;
            end
        end
    end

    // Register update with synchronous active-low clear taking priority.
    always_ff @(posedge clock) begin
        if (!clr_n) begin
            q_q    <= '0;
            done_q <= 1'b0;
            lim_q  <= c_lim_reset;
        end else begin
            q_q    <= q_d;
            done_q <= done_d;
            lim_q  <= lim_d;
        end
    end

`ifdef CONTADOR_PRESCALER_EN
    // Prescaler register, cleared together with the counter.
    always_ff @(posedge clock) begin
        if (!clr_n) begin
            pcnt_q <= '0;
        end else begin
            pcnt_q <= pcnt_d;
        end
    end
`endif

    assign Q    = q_q;
    assign done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_contador_prog.sv
`default_nettype none
// ============================================================================
//  Module      : tb_contador_prog
//  Description : Self-checking bench for contador_prog. Directed sequences
//                with literal expectations plus a behavioural model that is
//                compared against Q/done/rco every cycle.
//                Prescaler scenario active when CONTADOR_PRESCALER_EN is set.
//  Revision    : 1.0 - initial release
// ============================================================================

module tb_contador_prog;

    localparam int N = 16;
    localparam int LIMRST = 2000;

    logic          clock = 1'b0;
    logic          clr_n, ld, ent, enp, up, one_shot, wr_lim;
    logic [N-1:0]  D, lim_in;
    logic [N-1:0]  Q;
    logic          rco, done;
`ifdef CONTADOR_PRESCALER_EN
    logic [7:0]    presc;
`endif

    int n_checks = 0;
    int n_pass   = 0;
    bit chk_en   = 1'b0;

    contador_prog #(.N(N), .LIMITE_RESET(LIMRST)) dut (
        .clock    (clock),
        .clr_n    (clr_n),
        .ld       (ld),
        .D        (D),
        .ent      (ent),
        .enp      (enp),
        .up       (up),
        .one_shot (one_shot),
        .wr_lim   (wr_lim),
        .lim_in   (lim_in),
`ifdef CONTADOR_PRESCALER_EN
        .presc    (presc),
`endif
        .Q        (Q),
        .rco      (rco),
        .done     (done)
    );

    always #5 clock = ~clock;

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [N-1:0] q;
        logic         fin;
        logic [N-1:0] lim;
        logic [7:0]   pc;
    } mstate_t;

    mstate_t m = '{q: '0, fin: 1'b0, lim: N'(LIMRST), pc: 8'd0};

    function automatic mstate_t model_next(mstate_t s);
        mstate_t n = s;
        bit at_end;
        if (!clr_n) begin
            n.q = '0; n.fin = 1'b0; n.lim = N'(LIMRST); n.pc = 8'd0;
            return n;
        end
        if (wr_lim) n.lim = lim_in;
        if (ld) begin
            n.q = D; n.fin = 1'b0; n.pc = 8'd0;
        end else if (ent && enp && !s.fin) begin
`ifdef CONTADOR_PRESCALER_EN
            if (s.pc < presc) begin
                n.pc = s.pc + 8'd1;
                return n;
            end
            n.pc = 8'd0;
`endif
            at_end = up ? (int'(s.q) >= int'(s.lim)) : (s.q == 0);
            if (!at_end)        n.q = N'(up ? int'(s.q) + 1 : int'(s.q) - 1);
            else if (!one_shot) n.q = up ? '0 : s.lim;
            else                n.fin = 1'b1;
        end
        return n;
    endfunction

    always @(posedge clock) m <= model_next(m);

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        else n_pass++;
    endtask

    // Continuous comparison against the model, away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("model_Q", 32'(Q), 32'(m.q));
            check("model_done", 32'(done), 32'(m.fin));
            check("model_rco", 32'(rco),
                  32'(ent && (up ? (int'(m.q) >= int'(m.lim)) : (m.q == 0))));
        end
    end

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic cycn(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        clr_n = 1'b0; ld = 1'b0; D = '0; ent = 1'b0; enp = 1'b0; up = 1'b1;
        one_shot = 1'b0; wr_lim = 1'b0; lim_in = '0;
`ifdef CONTADOR_PRESCALER_EN
        presc = 8'd0;
`endif
        cycn(2);
        chk_en = 1'b1;
        check("rst_Q", 32'(Q), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_rco_ent0", 32'(rco), 32'd0);
        ent = 1'b1; #1;
        check("rst_rco_ent1", 32'(rco), 32'd0);

        // Up count, LIM=3, auto-reload
        clr_n = 1'b1; wr_lim = 1'b1; lim_in = 16'd3;
        cyc();
        wr_lim = 1'b0; enp = 1'b1;
        check("up_Q0", 32'(Q), 32'd0);
        cyc(); check("up_Q1", 32'(Q), 32'd1); check("up_rco_at1", 32'(rco), 32'd0);
        cyc(); check("up_Q2", 32'(Q), 32'd2);
        cyc(); check("up_Q3", 32'(Q), 32'd3); check("up_rco_at3", 32'(rco), 32'd1);
        cyc(); check("up_wrap0", 32'(Q), 32'd0); check("up_rco_at0", 32'(rco), 32'd0);
        cyc(); check("up_Q1b", 32'(Q), 32'd1);

        // Down count, ld 2, LIM=5
        enp = 1'b0; up = 1'b0; ld = 1'b1; D = 16'd2; wr_lim = 1'b1; lim_in = 16'd5;
        cyc();
        check("dn_ld2", 32'(Q), 32'd2);
        ld = 1'b0; wr_lim = 1'b0; enp = 1'b1;
        cyc(); check("dn_Q1", 32'(Q), 32'd1);
        cyc(); check("dn_Q0", 32'(Q), 32'd0); check("dn_rco_at0", 32'(rco), 32'd1);
        cyc(); check("dn_reload5", 32'(Q), 32'd5);
        cyc(); check("dn_Q4", 32'(Q), 32'd4);
        cycn(4); check("dn_back0", 32'(Q), 32'd0);
        ent = 1'b0; #1;
        check("dn_rco_ent0", 32'(rco), 32'd0);
        cyc(); check("dn_hold_ent0", 32'(Q), 32'd0);

        // One-shot up, LIM=2
        ent = 1'b1; enp = 1'b0; one_shot = 1'b1; up = 1'b1; ld = 1'b1; D = '0;
        wr_lim = 1'b1; lim_in = 16'd2;
        cyc();
        ld = 1'b0; wr_lim = 1'b0; enp = 1'b1;
        check("os_Q0", 32'(Q), 32'd0);
        cyc(); check("os_Q1", 32'(Q), 32'd1);
        cyc(); check("os_Q2", 32'(Q), 32'd2); check("os_done_pre", 32'(done), 32'd0);
        cyc(); check("os_hold2", 32'(Q), 32'd2); check("os_done", 32'(done), 32'd1);
        cyc(); check("os_hold2b", 32'(Q), 32'd2); check("os_done_sticky", 32'(done), 32'd1);
        ld = 1'b1; D = '0;
        cyc(); check("os_ld_Q", 32'(Q), 32'd0); check("os_ld_done", 32'(done), 32'd0);
        ld = 1'b0;
        cyc(); check("os_resume", 32'(Q), 32'd1);

        // Limit shrink below Q, then clear vs load on the same edge
        one_shot = 1'b0; enp = 1'b0; ld = 1'b1; D = 16'd10;
        cyc(); check("lim_ld10", 32'(Q), 32'd10);
        ld = 1'b0; wr_lim = 1'b1; lim_in = 16'd4;
        cyc();
        wr_lim = 1'b0; enp = 1'b1; #1;
        check("lim_rco_above", 32'(rco), 32'd1);
        cyc(); check("lim_wrap0", 32'(Q), 32'd0);
        enp = 1'b0; clr_n = 1'b0; ld = 1'b1; D = 16'd7; wr_lim = 1'b1; lim_in = 16'd9;
        cyc(); check("clr_beats_ld", 32'(Q), 32'd0);
        clr_n = 1'b1; wr_lim = 1'b0; D = 16'd2000;
        cyc(); ld = 1'b0; #1;
        check("clr_lim2000_rco", 32'(rco), 32'd1);
        ld = 1'b1; D = 16'd1999;
        cyc(); ld = 1'b0; #1;
        check("clr_lim1999_rco", 32'(rco), 32'd0);

        // Enable gating
        up = 1'b1; ent = 1'b1; ld = 1'b1; D = '0;
        cyc(); ld = 1'b0;
        enp = 1'b1; cyc(); check("en_p1", 32'(Q), 32'd1);
        enp = 1'b0; cyc(); check("en_p0_hold", 32'(Q), 32'd1);
        enp = 1'b1; cyc(); check("en_p1b", 32'(Q), 32'd2);
        ent = 1'b0; cyc(); check("en_t0_hold", 32'(Q), 32'd2);
        ld = 1'b1; D = 16'd2000;
        cyc(); ld = 1'b0;
        cyc(); check("en_t0_term_hold", 32'(Q), 32'd2000);
        check("en_t0_rco", 32'(rco), 32'd0);
        ent = 1'b1; #1;
        check("en_t1_rco", 32'(rco), 32'd1);
        ent = 1'b0;

        // LIM=0 degenerate: Q pinned at 0, rco follows ent
        up = 1'b0; ent = 1'b1; enp = 1'b0; wr_lim = 1'b1; lim_in = '0; ld = 1'b1; D = '0;
        cyc();
        wr_lim = 1'b0; ld = 1'b0; enp = 1'b1;
        cycn(3); check("lim0_dn_Q", 32'(Q), 32'd0); check("lim0_rco", 32'(rco), 32'd1);
        up = 1'b1;
        cycn(3); check("lim0_up_Q", 32'(Q), 32'd0);

        // Mixed traffic checked by the model only
        for (int i = 0; i < 80; i++) begin
            clr_n    = ($urandom_range(0, 39) != 0);
            ent      = ($urandom_range(0, 3) != 0);
            enp      = ($urandom_range(0, 3) != 0);
            up       = $urandom_range(0, 1) == 1;
            one_shot = ($urandom_range(0, 7) == 0);
            ld       = ($urandom_range(0, 9) == 0);
            D        = N'($urandom_range(0, 8));
            wr_lim   = ($urandom_range(0, 7) == 0);
            lim_in   = N'($urandom_range(0, 6));
            cyc();
        end
        clr_n = 1'b1; ld = 1'b0; wr_lim = 1'b0; one_shot = 1'b0;

`ifdef CONTADOR_PRESCALER_EN
        // Prescaler: one step every presc+1 qualified cycles
        up = 1'b1; ent = 1'b1; enp = 1'b0; ld = 1'b1; D = '0;
        wr_lim = 1'b1; lim_in = 16'd100; presc = 8'd2;
        cyc();
        ld = 1'b0; wr_lim = 1'b0; enp = 1'b1;
        check("ps_Q_s0", 32'(Q), 32'd0);
        cyc(); check("ps_Q_s1", 32'(Q), 32'd0);
        cyc(); check("ps_Q_s2", 32'(Q), 32'd0);
        cyc(); check("ps_Q_s3", 32'(Q), 32'd1);
        cyc(); check("ps_Q_s4", 32'(Q), 32'd1);
        cyc(); check("ps_Q_s5", 32'(Q), 32'd1);
        cyc(); check("ps_Q_s6", 32'(Q), 32'd2);
`endif

        cyc();
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
